pipe_perf_monitor: RTL and testbench
====================================

Name: pipe_perf_monitor

Overview:
- Cycle-accurate performance and termination monitor for the 5-stage pipelined CPU.
- Instantiated inside the CPU top.
- Consumes per-cycle pipeline events from the hazard unit, control unit and WB stage: stall, flush, retire and retired-NOP.
- Produces saturating event counters and a sticky done flag. The simulation bench reads these to report stall/flush totals and to decide when to stop.

Parameters:
CNT_W, 32, width of every event counter.
MAX_CYCLES, 30, RUN cycles after which monitor enters DONE; 0 disables cycle limit.
NOP_LIMIT, 8, consecutive retired NOPs that signal end of program; legal range 1..255.

Ports:
clk_i  input  1  clock, all state updates on rising edge.
rst_i  input  1  asynchronous active-low reset.
start_i  input  1  CPU start; monitor counts only while in RUN.
clr_i  input  1  synchronous clear of counters and state.
stall_i  input  1  hazard unit stall (PC/IF-ID hold) this cycle.
flush_i  input  1  IF/ID flush (taken branch/jump) this cycle.
retire_i  input  1  valid instruction in WB this cycle.
retire_nop_i  input  1  retiring instruction word is 32'b0; qualified by retire_i.
cycle_cnt_o  output  CNT_W  RUN cycles counted.
stall_cnt_o  output  CNT_W  stall cycles counted.
flush_cnt_o  output  CNT_W  flush cycles counted.
retire_cnt_o  output  CNT_W  retired non-NOP instructions.
state_o  output  2  00 IDLE, 01 RUN, 10 DONE.
done_o  output  1  high while in DONE.

Behaviour:
- Reset (rst_i=0, asynchronous): all counters 0, internal nop_run 0, state IDLE, done_o 0. Held while rst_i=0.
- Priority at each edge: reset, then clr_i, then normal operation.
- clr_i=1:
  - Zero all counters and nop_run; state becomes IDLE.
  - start_i and all events in the same cycle are ignored.
- IDLE: start_i=1 moves to RUN at the next edge. No counting in the cycle start_i is first sampled.
- RUN, start_i=0: return to IDLE; counters hold (pause, no clear).
- RUN, start_i=1, per edge. All events are judged on the state before the edge.
  - cycle_cnt += 1.
  - flush_i=1: flush_cnt += 1.
  - stall_i=1 and flush_i=0: stall_cnt += 1. A stall coincident with a flush counts as flush only.
  - retire_i=1 and retire_nop_i=0: retire_cnt += 1, nop_run cleared.
  - retire_i=1 and retire_nop_i=1: nop_run += 1 (saturates at 255).
  - retire_i=0: nop_run holds (bubbles neither extend nor break a NOP run).
- RUN to DONE at the edge where either condition holds:
  - MAX_CYCLES != 0 and cycle_cnt == MAX_CYCLES-1. After that edge cycle_cnt reads MAX_CYCLES.
  - A retiring NOP makes nop_run reach NOP_LIMIT.
- The final RUN cycle's events are still counted.
- DONE: sticky; counters frozen; start_i ignored. Exit only via clr_i or reset.
- Counters saturate at all-ones (no wrap). Saturation of one counter does not affect the others or the state.
- done_o == (state_o == 2'b10). Outputs are direct register values; no combinational path from inputs.
- Reset asserted mid-RUN: immediate return to IDLE with zeroed counters, independent of clock.
- state_o 2'b11 is unreachable; if reached, recover to IDLE at the next edge.

Test Plan:
- Reset, then start_i=1 with no events for 40 cycles, defaults: cycle_cnt_o steps 1..30; state_o=10 and done_o=1 after edge 30; cycle_cnt_o stays 30 thereafter.
- In RUN, 3 cycles stall_i=1 alone, then 2 cycles stall_i=1 with flush_i=1: stall_cnt_o=3, flush_cnt_o=2.
- Retire pattern ADD, NOP×5, bubble, NOP×3 (MAX_CYCLES=0): retire_cnt_o=1; done_o rises at the edge of the 8th NOP (bubble does not reset the run).
- Retire NOP×7, ADD, NOP×7: no DONE; retire_cnt_o=1; nop_run restarts after ADD.
- CNT_W=4, MAX_CYCLES=0, 20 stall cycles: stall_cnt_o saturates at 15; cycle_cnt_o saturates at 15; state stays RUN.
- In RUN after 10 cycles, drop start_i for 5 cycles, then raise again: cycle_cnt_o holds 10 during pause, then resumes at 11. Pulse clr_i together with start_i=1: counters 0, state IDLE. Assert rst_i=0 mid-clock in RUN: outputs zero immediately.

Source files
------------

// File: rtl/pipe_perf_monitor_if.sv
// rtl/pipe_perf_monitor_if.sv - pipeline event inputs and counter outputs of the performance monitor
interface pipe_perf_monitor_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic             clr_i;
  logic             stall_i;
  logic             flush_i;
  logic             retire_i;
  logic             retire_nop_i;
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic [CNT_W-1:0] retire_cnt_o;
  logic [1:0]       state_o;
  logic             done_o;

  // CPU side: produces pipeline events, reads back statistics
  modport master (
    output start_i, clr_i, stall_i, flush_i, retire_i, retire_nop_i,
    input  cycle_cnt_o, stall_cnt_o, flush_cnt_o, retire_cnt_o, state_o, done_o
  );

  modport slave (
    input  start_i, clr_i, stall_i, flush_i, retire_i, retire_nop_i,
    output cycle_cnt_o, stall_cnt_o, flush_cnt_o, retire_cnt_o, state_o, done_o
  );
endinterface

// File: rtl/pipe_perf_monitor.sv
// rtl/pipe_perf_monitor.sv - saturating stall/flush/retire counters and sticky end-of-program detection
module pipe_perf_monitor #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 30,
  parameter int NOP_LIMIT  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pipe_perf_monitor_if.slave   mon
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Cycle limit is compared at a width that holds both the counter and the 32-bit parameter
  localparam int               EXT_W    = (CNT_W > 32) ? CNT_W : 32;
  localparam logic [EXT_W-1:0] CYC_LAST = EXT_W'(MAX_CYCLES - 1);
  localparam logic [7:0]       NOP_LIM  = 8'(NOP_LIMIT);
  localparam logic [7:0]       NOP_SAT  = 8'hFF;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] retire_cnt;
  logic [7:0]       nop_run;
  logic [7:0]       nop_run_inc;
  logic             count_en;
  logic             cyc_hit;
  logic             nop_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign count_en    = (state == ST_RUN) && mon.start_i && !mon.clr_i;
  assign nop_run_inc = (nop_run == NOP_SAT) ? NOP_SAT : nop_run + 8'd1;
  assign cyc_hit     = (MAX_CYCLES != 0) && (EXT_W'(cycle_cnt) == CYC_LAST);
  assign nop_hit     = mon.retire_i && mon.retire_nop_i && (nop_run_inc == NOP_LIM);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (mon.clr_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mon.start_i) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!mon.start_i)          state_nxt = ST_IDLE;
          else if (cyc_hit || nop_hit) state_nxt = ST_DONE;
        end
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // A stall that coincides with a flush is attributed to the flush only
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_cnt  <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
      nop_run    <= '0;
    end else if (mon.clr_i) begin
      cycle_cnt  <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
      nop_run    <= '0;
    end else if (count_en) begin
      cycle_cnt <= sat_inc(cycle_cnt);
      if (mon.flush_i) begin
        flush_cnt <= sat_inc(flush_cnt);
      end else if (mon.stall_i) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (mon.retire_i) begin
        if (mon.retire_nop_i) begin
          nop_run <= nop_run_inc;
        end else begin
          retire_cnt <= sat_inc(retire_cnt);
          nop_run    <= '0;
        end
      end
    end
  end

  assign mon.cycle_cnt_o  = cycle_cnt;
  assign mon.stall_cnt_o  = stall_cnt;
  assign mon.flush_cnt_o  = flush_cnt;
  assign mon.retire_cnt_o = retire_cnt;
  assign mon.state_o      = state;
  assign mon.done_o       = (state == ST_DONE);

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb/tb_pipe_perf_monitor.sv - three monitor configurations driven in lockstep against an arithmetic reference model
module tb_pipe_perf_monitor;

  logic clk = 1'b0;
  logic rst;
  logic start, clr, stall, flush, retire, rnop;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_perf_monitor_if #(.CNT_W(32)) bus0 ();
  pipe_perf_monitor_if #(.CNT_W(32)) bus1 ();
  pipe_perf_monitor_if #(.CNT_W(4))  bus2 ();

  assign bus0.start_i = start;  assign bus0.clr_i = clr;  assign bus0.stall_i = stall;
  assign bus0.flush_i = flush;  assign bus0.retire_i = retire;  assign bus0.retire_nop_i = rnop;
  assign bus1.start_i = start;  assign bus1.clr_i = clr;  assign bus1.stall_i = stall;
  assign bus1.flush_i = flush;  assign bus1.retire_i = retire;  assign bus1.retire_nop_i = rnop;
  assign bus2.start_i = start;  assign bus2.clr_i = clr;  assign bus2.stall_i = stall;
  assign bus2.flush_i = flush;  assign bus2.retire_i = retire;  assign bus2.retire_nop_i = rnop;

  pipe_perf_monitor #(.CNT_W(32), .MAX_CYCLES(30), .NOP_LIMIT(8)) dut0 (.clk_i(clk), .rst_i(rst), .mon(bus0.slave));
  pipe_perf_monitor #(.CNT_W(32), .MAX_CYCLES(0),  .NOP_LIMIT(8)) dut1 (.clk_i(clk), .rst_i(rst), .mon(bus1.slave));
  pipe_perf_monitor #(.CNT_W(4),  .MAX_CYCLES(0),  .NOP_LIMIT(8)) dut2 (.clk_i(clk), .rst_i(rst), .mon(bus2.slave));

  logic [31:0] o_cyc [3];
  logic [31:0] o_stl [3];
  logic [31:0] o_fls [3];
  logic [31:0] o_ret [3];
  logic [1:0]  o_st  [3];
  logic        o_done[3];

  assign o_cyc[0] = bus0.cycle_cnt_o;        assign o_stl[0] = bus0.stall_cnt_o;
  assign o_fls[0] = bus0.flush_cnt_o;        assign o_ret[0] = bus0.retire_cnt_o;
  assign o_st[0]  = bus0.state_o;            assign o_done[0] = bus0.done_o;
  assign o_cyc[1] = bus1.cycle_cnt_o;        assign o_stl[1] = bus1.stall_cnt_o;
  assign o_fls[1] = bus1.flush_cnt_o;        assign o_ret[1] = bus1.retire_cnt_o;
  assign o_st[1]  = bus1.state_o;            assign o_done[1] = bus1.done_o;
  assign o_cyc[2] = 32'(bus2.cycle_cnt_o);   assign o_stl[2] = 32'(bus2.stall_cnt_o);
  assign o_fls[2] = 32'(bus2.flush_cnt_o);   assign o_ret[2] = 32'(bus2.retire_cnt_o);
  assign o_st[2]  = bus2.state_o;            assign o_done[2] = bus2.done_o;

  // Reference model: state 0 idle, 1 run, 2 done; counters as plain integers clipped at cap
  longint cap  [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  longint maxc [3] = '{30, 0, 0};
  int     nlim [3] = '{8, 8, 8};
  int     m_st [3];
  longint m_cyc[3], m_stl[3], m_fls[3], m_ret[3];
  int     m_nr [3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint clip(input longint v, input longint c);
    return (v > c) ? c : v;
  endfunction

  task automatic model_zero(input int d);
    m_st[d] = 0; m_cyc[d] = 0; m_stl[d] = 0; m_fls[d] = 0; m_ret[d] = 0; m_nr[d] = 0;
  endtask

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      bit hit;
      hit = 1'b0;
      if (!rst || clr) begin
        model_zero(d);
      end else if (m_st[d] == 0) begin
        if (start) m_st[d] = 1;
      end else if (m_st[d] == 1) begin
        if (!start) begin
          m_st[d] = 0;
        end else begin
          hit = (maxc[d] != 0) && (m_cyc[d] == maxc[d] - 1);
          m_cyc[d] = clip(m_cyc[d] + 1, cap[d]);
          if (flush)      m_fls[d] = clip(m_fls[d] + 1, cap[d]);
          else if (stall) m_stl[d] = clip(m_stl[d] + 1, cap[d]);
          if (retire && !rnop) begin
            m_ret[d] = clip(m_ret[d] + 1, cap[d]);
            m_nr[d]  = 0;
          end else if (retire && rnop) begin
            m_nr[d] = (m_nr[d] + 1 > 255) ? 255 : m_nr[d] + 1;
            if (m_nr[d] == nlim[d]) hit = 1'b1;
          end
          if (hit) m_st[d] = 2;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("cyc%0d", d),   o_cyc[d],  m_cyc[d]);
      check($sformatf("stall%0d", d), o_stl[d],  m_stl[d]);
      check($sformatf("flush%0d", d), o_fls[d],  m_fls[d]);
      check($sformatf("ret%0d", d),   o_ret[d],  m_ret[d]);
      check($sformatf("state%0d", d), o_st[d],   m_st[d]);
      check($sformatf("done%0d", d),  o_done[d], (m_st[d] == 2));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit s, input bit st, input bit f, input bit r, input bit n);
    clr = 1'b0; start = s; stall = st; flush = f; retire = r; rnop = n;
  endtask

  task automatic do_clr();
    clr = 1'b1; start = 1'b1; stall = 1'b1; flush = 1'b1; retire = 1'b1; rnop = 1'b0;
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int d = 0; d < 3; d++) model_zero(d);
    @(posedge clk);
    #1;
    compare_all();
    repeat (2) step();
    rst = 1'b1;

    // Free run to the cycle limit on dut0
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (40) step();
    check("t1_cyc0", o_cyc[0], 30);
    check("t1_done0", o_done[0], 1);
    check("t1_cyc2", o_cyc[2], 15);

    do_clr();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) step();
    check("t2_stall1", o_stl[1], 3);
    check("t2_flush1", o_fls[1], 2);

    // ADD, NOP x5, bubble, NOP x3
    do_clr();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1); repeat (5) step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1); repeat (2) step();
    check("t3_pre_done1", o_done[1], 0);
    step();
    check("t3_done1", o_done[1], 1);
    check("t3_ret1", o_ret[1], 1);

    // NOP x7, ADD, NOP x7 then one more NOP
    do_clr();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1); repeat (7) step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1); repeat (7) step();
    check("t4_done1", o_done[1], 0);
    check("t4_ret1", o_ret[1], 1);
    step();
    check("t4_done1_late", o_done[1], 1);

    do_clr();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) step();
    check("t5_stall2", o_stl[2], 15);
    check("t5_cyc2", o_cyc[2], 15);
    check("t5_state2", o_st[2], 1);

    // Pause/resume, clear, then asynchronous reset mid-RUN
    do_clr();
    repeat (10) step();
    check("t6_cyc1", o_cyc[1], 10);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) step();
    check("t6_pause_cyc1", o_cyc[1], 10);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    check("t6_resume_cyc1", o_cyc[1], 11);
    clr = 1'b1;
    step();
    check("t6_clr_cyc1", o_cyc[1], 0);
    check("t6_clr_state1", o_st[1], 0);
    clr = 1'b0;
    repeat (4) step();
    #2;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) model_zero(d);
    #1;
    compare_all();
    check("t6_rst_cyc1", o_cyc[1], 0);
    check("t6_rst_state1", o_st[1], 0);
    step();
    rst = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      clr    = ($urandom % 64) == 0;
      start  = ($urandom % 16) != 0;
      stall  = ($urandom % 4) == 0;
      flush  = ($urandom % 6) == 0;
      retire = ($urandom % 2) == 0;
      rnop   = ($urandom % 3) != 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
